// File: rtl/eth_tx_scheduler.sv
// Round-robin scheduler for the shared 10BASE-T transmit datapath.
// Grants one source per frame, pulses o_tx_start, enforces the inter-packet
// gap, emits normal link pulses only on an idle line and aborts hung frames.
//
// state | meaning
// IDLE  | line quiet; arbitrate requests, count towards the next link pulse
// START | one-cycle start strobe to the datapath for the granted source
// SEND  | frame in flight; wait for i_tx_done or watchdog expiry
// IPG   | inter-packet gap after a frame or a link pulse
// NLP   | link pulse driven to the output stage
module eth_tx_scheduler #(
    parameter int N_REQ          = 4,
    parameter int IPG_CYCLES     = 192,
    parameter int NLP_PERIOD     = 262144,
    parameter int NLP_WIDTH      = 2,
    parameter int TIMEOUT_CYCLES = 32768,
    localparam int SEL_W         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_gnt,
    output logic [SEL_W-1:0] o_tx_sel,
    output logic             o_tx_start,
    input  logic             i_tx_done,
    output logic             o_nlp,
    output logic             o_busy,
    output logic             o_err_timeout
);

    localparam int NLP_W  = (NLP_PERIOD > 1) ? $clog2(NLP_PERIOD) : 1;
    localparam int WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int PH_MAX = (IPG_CYCLES > NLP_WIDTH) ? IPG_CYCLES : NLP_WIDTH;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_SEND  = 3'd2,
        S_IPG   = 3'd3,
        S_NLP   = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [NLP_W-1:0]   nlp_cnt_q, nlp_cnt_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               nlp_q, nlp_d;
    logic               err_q, err_d;

    logic               win_found;
    logic [SEL_W-1:0]   win_idx;
    logic [SEL_W-1:0]   cand;

    // Round-robin pick: scan from the farthest offset down so the first set
    // request at or above the pointer is the last one written.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (int'(ptr_q) + i >= N_REQ) begin
                cand = SEL_W'(int'(ptr_q) + i - N_REQ);
            end else begin
                cand = SEL_W'(int'(ptr_q) + i);
            end
            if (i_req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Next-state, counters and next registered output values.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        nlp_cnt_d = nlp_cnt_q;
        wd_d      = wd_q;
        ph_d      = ph_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        start_d   = 1'b0;
        busy_d    = busy_q;
        nlp_d     = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    // A request beats a coinciding link pulse.
                    state_d   = S_START;
                    ptr_d     = (win_idx == SEL_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                    gnt_d     = N_REQ'(1) << win_idx;
                    sel_d     = win_idx;
                    start_d   = 1'b1;
                    busy_d    = 1'b1;
                    nlp_cnt_d = '0;
                    wd_d      = '0;
                end else if (nlp_cnt_q == NLP_W'(NLP_PERIOD - 1)) begin
                    state_d   = S_NLP;
                    nlp_d     = 1'b1;
                    ph_d      = PH_W'(NLP_WIDTH - 1);
                    nlp_cnt_d = '0;
                end else begin
                    nlp_cnt_d = nlp_cnt_q + 1'b1;
                end
            end
            S_START: begin
                // Watchdog runs from the start strobe so its limit is start-to-done.
                state_d = S_SEND;
                wd_d    = wd_q + 1'b1;
            end
            S_SEND: begin
                if (i_tx_done || wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d     = ~i_tx_done;
                    state_d   = S_IPG;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    ph_d      = PH_W'(IPG_CYCLES - 1);
                    nlp_cnt_d = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_IPG: begin
                if (ph_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    ph_d = ph_q - 1'b1;
                end
            end
            S_NLP: begin
                if (ph_q == '0) begin
                    state_d   = S_IPG;
                    ph_d      = PH_W'(IPG_CYCLES - 1);
                    nlp_cnt_d = '0;
                end else begin
                    nlp_d = 1'b1;
                    ph_d  = ph_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counters and output registers; reset aborts any frame at once.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            nlp_cnt_q <= '0;
            wd_q      <= '0;
            ph_q      <= '0;
            gnt_q     <= '0;
            sel_q     <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            nlp_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            nlp_cnt_q <= nlp_cnt_d;
            wd_q      <= wd_d;
            ph_q      <= ph_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            nlp_q     <= nlp_d;
            err_q     <= err_d;
        end
    end

    assign o_gnt         = gnt_q;
    assign o_tx_sel      = sel_q;
    assign o_tx_start    = start_q;
    assign o_busy        = busy_q;
    assign o_nlp         = nlp_q;
    assign o_err_timeout = err_q;

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Self-checking bench for eth_tx_scheduler with shortened timing parameters.
module tb_eth_tx_scheduler;

    localparam int N   = 4;
    localparam int IPG = 12;
    localparam int P   = 200;
    localparam int W   = 2;
    localparam int TO  = 300;

    logic       i_clk;
    logic       i_rst_n;
    logic [3:0] i_req;
    logic [3:0] o_gnt;
    logic [1:0] o_tx_sel;
    logic       o_tx_start;
    logic       i_tx_done;
    logic       o_nlp;
    logic       o_busy;
    logic       o_err_timeout;

    eth_tx_scheduler #(
        .N_REQ(N), .IPG_CYCLES(IPG), .NLP_PERIOD(P),
        .NLP_WIDTH(W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .o_gnt(o_gnt),
        .o_tx_sel(o_tx_sel), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
        .o_nlp(o_nlp), .o_busy(o_busy), .o_err_timeout(o_err_timeout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc;

    // Reference model: timestamps of frame start, pulse start and the first
    // cycle the line is free again; pointer kept as a plain integer.
    int m_fs, m_free, m_nlp, m_ptr;
    logic [3:0] e_gnt;
    logic [1:0] e_sel;
    logic e_start, e_busy, e_nlp, e_err;

    // Observed events
    int   n_start, n_err, n_nlp_hi;
    int   last_start, last_err, last_drop;
    int   nlp_rises[$];
    logic nlp_prev;
    logic [3:0] prev_gnt;

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp_gnt;
        logic [1:0] exp_sel;
        int         len;
        logic       early;
    } rr_vec_t;
    rr_vec_t vecs[10];

    task automatic check_val(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_fs = -1; m_free = 0; m_nlp = -1; m_ptr = 0;
        e_gnt = '0; e_sel = '0; e_start = 0; e_busy = 0; e_nlp = 0; e_err = 0;
        n_start = 0; n_err = 0; n_nlp_hi = 0;
        last_start = -1; last_err = -1; last_drop = -1;
        nlp_rises.delete();
        nlp_prev = 0; prev_gnt = '0;
        cyc = 0;
    endtask

    // Predict the registered outputs of cycle cyc+1 from the inputs of cyc.
    task automatic model_step(input logic [3:0] req, input logic done);
        int k, c, w;
        bit found;
        e_start = 0; e_err = 0; e_nlp = 0;
        if (m_fs >= 0) begin
            k = cyc - m_fs;
            if (k > 0 && (done || k == TO - 1)) begin
                e_err  = !done;
                m_fs   = -1;
                m_free = cyc + 1 + IPG;
                e_gnt  = '0;
                e_busy = 0;
            end
        end else if (m_nlp >= 0) begin
            if (cyc + 1 < m_nlp + W) begin
                e_nlp = 1;
            end else begin
                m_nlp  = -1;
                m_free = cyc + 1 + IPG;
            end
        end else if (cyc >= m_free) begin
            if (req != 4'b0000) begin
                found = 0; w = 0;
                for (int i = 0; i < N; i++) begin
                    c = (m_ptr + i) % N;
                    if (!found && req[c]) begin
                        found = 1;
                        w = c;
                    end
                end
                e_gnt   = 4'(1 << w);
                e_sel   = 2'(w);
                e_start = 1;
                e_busy  = 1;
                m_fs    = cyc + 1;
                m_ptr   = (w + 1) % N;
            end else if (cyc - m_free == P - 1) begin
                m_nlp = cyc + 1;
                e_nlp = 1;
            end
        end
    endtask

    task automatic tick(input logic [3:0] req, input logic done);
        i_req     = req;
        i_tx_done = done;
        model_step(req, done);
        @(posedge i_clk);
        #1;
        cyc++;
        n_cmp++;
        if ({o_gnt, o_tx_start, o_busy, o_nlp, o_err_timeout} !== {e_gnt, e_start, e_busy, e_nlp, e_err}
            || (e_busy && o_tx_sel !== e_sel)) begin
            n_fail++;
            $display("FAIL cycle_outputs @cyc %0d: got gnt=%b sel=%0d start=%b busy=%b nlp=%b err=%b expected gnt=%b sel=%0d start=%b busy=%b nlp=%b err=%b",
                     cyc, o_gnt, o_tx_sel, o_tx_start, o_busy, o_nlp, o_err_timeout,
                     e_gnt, e_sel, e_start, e_busy, e_nlp, e_err);
        end
        if (o_tx_start) begin last_start = cyc; n_start++; end
        if (o_err_timeout) begin last_err = cyc; n_err++; end
        if (o_nlp) n_nlp_hi++;
        if (o_nlp && !nlp_prev) nlp_rises.push_back(cyc);
        nlp_prev = o_nlp;
        if (prev_gnt != 4'b0000 && o_gnt == 4'b0000) last_drop = cyc;
        prev_gnt = o_gnt;
    endtask

    task automatic do_reset();
        i_rst_n = 0; i_req = '0; i_tx_done = 0;
        repeat (2) @(posedge i_clk);
        #1;
        check_val("reset_outputs", int'({o_gnt, o_tx_sel, o_tx_start, o_busy, o_nlp, o_err_timeout}), 0);
        #1;
        i_rst_n = 1;
        model_reset();
    endtask

    task automatic run_until_start(input logic [3:0] req, input int bound, input string name);
        int seen;
        seen = n_start;
        for (int i = 0; i < bound && n_start == seen; i++) tick(req, 1'b0);
        check_val(name, int'(n_start != seen), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] pend;
        logic       dn;
        int         err_at;

        vecs[0] = '{4'b1111, 4'b0001, 2'd0, 8,  1'b0};
        vecs[1] = '{4'b1111, 4'b0010, 2'd1, 1,  1'b0};
        vecs[2] = '{4'b1111, 4'b0100, 2'd2, 20, 1'b1};
        vecs[3] = '{4'b1111, 4'b1000, 2'd3, 5,  1'b0};
        vecs[4] = '{4'b1111, 4'b0001, 2'd0, 3,  1'b0};
        vecs[5] = '{4'b1001, 4'b1000, 2'd3, 6,  1'b1};
        vecs[6] = '{4'b0110, 4'b0010, 2'd1, 2,  1'b0};
        vecs[7] = '{4'b0001, 4'b0001, 2'd0, 4,  1'b0};
        vecs[8] = '{4'b1100, 4'b0100, 2'd2, 7,  1'b0};
        vecs[9] = '{4'b0100, 4'b0100, 2'd2, 3,  1'b0};

        // Idle line: two link pulses, no starts
        do_reset();
        repeat (2 * P + 2 * W + IPG + 10) tick(4'b0000, 1'b0);
        check_val("nlp_count", nlp_rises.size(), 2);
        if (nlp_rises.size() == 2) begin
            check_val("nlp_first", nlp_rises[0], P);
            check_val("nlp_second", nlp_rises[1], P + W + IPG + P);
        end
        check_val("nlp_width_total", n_nlp_hi, 2 * W);
        check_val("idle_no_start", n_start, 0);

        // Single request: latency, grant drop after done, gap to next start
        do_reset();
        repeat (10) tick(4'b0000, 1'b0);
        tick(4'b0010, 1'b0);
        check_val("single_start_cyc", last_start, 11);
        check_val("single_gnt", int'(o_gnt), 4'b0010);
        check_val("single_sel", int'(o_tx_sel), 1);
        while (cyc < 60) tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b1);
        check_val("single_gnt_clear", int'(o_gnt), 0);
        check_val("single_drop_cyc", last_drop, 61);
        run_until_start(4'b0010, 60, "single_restart_seen");
        check_val("single_gap_ok", int'(last_start >= 61 + IPG + 1), 1);

        // Round-robin table
        do_reset();
        foreach (vecs[i]) begin
            run_until_start(vecs[i].req, 60, "rr_start_seen");
            check_val("rr_gnt", int'(o_gnt), int'(vecs[i].exp_gnt));
            check_val("rr_sel", int'(o_tx_sel), int'(vecs[i].exp_sel));
            if (i > 0) check_val("rr_gap_ok", int'(last_start - last_drop >= IPG + 1), 1);
            tick(vecs[i].req, vecs[i].early);
            for (int k = 1; k < vecs[i].len; k++) tick(vecs[i].req, 1'b0);
            tick(vecs[i].req, 1'b1);
        end

        // Request coinciding with the link-pulse terminal count
        do_reset();
        repeat (P - 1) tick(4'b0000, 1'b0);
        tick(4'b0001, 1'b0);
        check_val("coll_start_cyc", last_start, P);
        repeat (10) tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b1);
        for (int i = 0; i < IPG + P + 20 && nlp_rises.size() == 0; i++) tick(4'b0000, 1'b0);
        check_val("coll_nlp_count", nlp_rises.size(), 1);
        if (nlp_rises.size() == 1) check_val("coll_nlp_cyc", nlp_rises[0], last_drop + IPG + P);

        // Watchdog: source 2 never finishes, source 3 follows
        do_reset();
        run_until_start(4'b0100, 5, "wd_start_seen");
        check_val("wd_sel", int'(o_tx_sel), 2);
        for (int i = 0; i < TO + 20 && n_err == 0; i++) tick(4'b1000, 1'b0);
        check_val("wd_err_seen", n_err, 1);
        check_val("wd_err_delay", last_err - last_start, TO);
        check_val("wd_gnt_drop", int'({o_gnt, o_busy}), 0);
        err_at = last_err;
        tick(4'b1000, 1'b0);
        check_val("wd_err_one_cycle", int'(o_err_timeout), 0);
        run_until_start(4'b1000, IPG + 10, "wd_next_seen");
        check_val("wd_next_sel", int'(o_tx_sel), 3);
        check_val("wd_next_delay", last_start - err_at, IPG + 1);

        // Asynchronous reset in the middle of a frame
        do_reset();
        run_until_start(4'b0100, 5, "ar_start_seen");
        repeat (3) tick(4'b0000, 1'b0);
        check_val("ar_busy_before", int'(o_busy), 1);
        #3;
        i_rst_n = 0;
        #1;
        check_val("ar_outputs_zero", int'({o_gnt, o_tx_sel, o_tx_start, o_busy, o_nlp, o_err_timeout}), 0);
        do_reset();
        run_until_start(4'b1010, 5, "ar_restart_seen");
        check_val("ar_first_sel", int'(o_tx_sel), 1);
        repeat (4) tick(4'b0000, 1'b0);
        tick(4'b0000, 1'b1);

        // Random traffic against the model: busy phase then sparse phase
        do_reset();
        pend = '0;
        for (int n = 0; n < 4000; n++) begin
            for (int s = 0; s < N; s++) begin
                if (!pend[s] && $urandom_range((n < 2000) ? 299 : 3999) == 0) pend[s] = 1'b1;
            end
            if (m_fs >= 0) dn = ($urandom_range(119) == 0);
            else           dn = ($urandom_range(199) == 0);
            tick(pend, dn);
            if (e_start) pend[e_sel] = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
